counter_0_9_chain: RTL and testbench
====================================

Name: counter_0_9_chain

Overview:
- Cascaded BCD up-counter, DIGITS decimal digits, each counting 0→9 with ripple carry into the next digit.
- Wraps, or saturates, at a programmable BCD terminal value (e.g. 59 for minutes/seconds).
- Counterpart to the 9→0 down-counting timer digits; used for elapsed-time and event-count displays feeding the BCD-to-7-segment stage.
- Synchronous load and clear allow software preset and zeroing.

Parameters:
- DIGITS, 2, number of BCD digits; legal range 1..4.
- MAX_BCD, 8'h59, terminal count in packed BCD, width 4*DIGITS; every nibble ≤ 9.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- init_n  input  1  asynchronous active-low reset; clears all digits.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_value.
- load_value  input  4*DIGITS  packed BCD preset value; digit 0 in [3:0].
- en  input  1  count enable; increments by one per enabled cycle.
- bcd_out  output  4*DIGITS  current count, packed BCD, registered.
- at_max  output  1  high when bcd_out == MAX_BCD; combinational from state.
- carry_out  output  1  en & at_max; combinational, for cascading into the next counter's en.

Behaviour:
- Reset: init_n low → bcd_out = 0 immediately, regardless of clk; at_max = (MAX_BCD == 0); carry_out = 0 while en = 0.
- Priority per rising edge: clear > load > en > hold.
- clear = 1: bcd_out ← 0 next edge.
- load = 1: bcd_out ← load_value next edge, with these sanitizing rules:
  - any nibble > 9 is loaded as 0;
  - if the sanitized value > MAX_BCD, the whole value loads as 0.
- en = 1, no clear/load, bcd_out ≠ MAX_BCD:
  - digit 0 increments;
  - a digit at 9 with incoming carry becomes 0 and passes a carry to the next digit;
  - the carry into digit 0 is en.
- en = 1 with bcd_out == MAX_BCD: bcd_out ← 0 next edge (wrap); carry_out = 1 during that cycle.
- Latency:
  - bcd_out reflects clear/load/en one edge after sampling.
  - at_max follows bcd_out combinationally in the same cycle.
  - carry_out follows en with zero latency.
- Increment arithmetic is per-digit BCD, never binary +1 on the packed vector; nibble values 10–15 are unreachable by counting.
- Top-digit overflow (all 9s) with MAX_BCD all 9s is the normal wrap-to-0 case.
- Simultaneous load and en: load wins, no increment that cycle, carry_out still equals en & at_max for the pre-load state.
- Reset asserted mid-count overrides everything; counting resumes from 0 on the first enabled edge after init_n deasserts.
- en held high continuously: one increment per cycle, no dead cycles at digit rollover.

Optional Feature:
- Macro COUNTER_0_9_SATURATE_EN.
- Defined: at bcd_out == MAX_BCD with en = 1, bcd_out holds at MAX_BCD (no wrap), carry_out forced 0, at_max stays 1. Only clear, load or init_n leave the max state.
- Undefined: wrap-to-0 with carry_out pulse as described in Behaviour.

Test Plan:
- Reset: init_n low mid-count at 8'h37 → bcd_out = 8'h00 before the next clk edge; release, en = 1 for 3 cycles → 8'h03.
- Digit rollover: load 8'h08, en = 1 for 3 cycles → 09, 10, 11; nibble never shows A–F.
- Wrap (MAX_BCD = 8'h59): load 8'h58, en = 1 → 59 with at_max = 1 and carry_out = 1 in that cycle, then 00 with at_max = 0.
- Load sanitizing: load 8'h3C → 8'h30; load 8'h75 (> 59) → 8'h00; load and en together at 8'h12 → 8'h12, not 13.
- Priority: clear, load (8'h44) and en all high from 8'h20 → 8'h00.
- COUNTER_0_9_SATURATE_EN defined: from 8'h58, en = 1 for 4 cycles → 59, 59, 59, 59; carry_out = 0 throughout; then clear → 00.

Source files
------------

// File: rtl/counter_0_9_chain_if.sv
// Control and status bundle for the cascaded BCD up-counter.
// The bench or host drives the master side; the counter is the slave.
interface counter_0_9_chain_if #(
  parameter int DIGITS = 2
);
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  en;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  at_max;
  logic                  carry_out;

  modport master (
    output clear, load, load_value, en,
    input  bcd_out, at_max, carry_out
  );

  modport slave (
    input  clear, load, load_value, en,
    output bcd_out, at_max, carry_out
  );
endinterface

// File: rtl/counter_0_9_chain.sv
// Cascaded BCD up-counter with ripple carry between digits and a programmable terminal value.
// Define COUNTER_0_9_SATURATE_EN to hold at MAX_BCD instead of wrapping to zero.
module counter_0_9_chain #(
  parameter int                  DIGITS  = 2,
  parameter logic [4*DIGITS-1:0] MAX_BCD = 8'h59
) (
  input  logic                        clk,
  input  logic                        init_n,
  counter_0_9_chain_if.slave          bus
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] bcd_q;
  logic [W-1:0] bcd_d;
  logic         at_max;

  // Bad nibbles become 0; a preset beyond the terminal count is rejected as a whole.
  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    // With every nibble <= 9, packed BCD orders the same as its decimal value.
    if (r > MAX_BCD) r = '0;
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign at_max = (bcd_q == MAX_BCD);

  always_comb begin
    bcd_d = bcd_q;
    if (bus.clear) begin
      bcd_d = '0;
    end else if (bus.load) begin
      bcd_d = sanitize(bus.load_value);
    end else if (bus.en) begin
      if (at_max) begin
`ifdef COUNTER_0_9_SATURATE_EN
        bcd_d = bcd_q;
`else
        bcd_d = '0;
`endif
      end else begin
        bcd_d = bcd_inc(bcd_q);
      end
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) bcd_q <= '0;
    else         bcd_q <= bcd_d;
  end

  assign bus.bcd_out = bcd_q;
  assign bus.at_max  = at_max;
`ifdef COUNTER_0_9_SATURATE_EN
  assign bus.carry_out = 1'b0;
`else
  assign bus.carry_out = bus.en & at_max;
`endif

endmodule

// File: tb/tb_counter_0_9_chain.sv
// Bench for counter_0_9_chain (DIGITS=2, MAX_BCD=8'h59): vector table plus reset sequence.
// Expectations follow COUNTER_0_9_SATURATE_EN when that macro is defined for the build.
module tb_counter_0_9_chain;

`ifdef COUNTER_0_9_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic init_n;
  int   checks;
  int   errors;

  counter_0_9_chain_if #(.DIGITS(2)) bus ();

  counter_0_9_chain #(.DIGITS(2), .MAX_BCD(8'h59)) dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clear;
    logic       load;
    logic [7:0] lv;
    logic       en;
    logic       pre_at_max;
    logic       pre_carry;
    logic [7:0] next_bcd;
  } vec_t;

  logic [7:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every edge that had an expectation pushed is checked just after it.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) chk("bcd_out", {24'd0, bus.bcd_out}, {24'd0, sb.pop_front()});
  end

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    bus.clear      = v.clear;
    bus.load       = v.load;
    bus.load_value = v.lv;
    bus.en         = v.en;
    #1;
    chk({tag, " at_max"},    {31'd0, bus.at_max},    {31'd0, v.pre_at_max});
    chk({tag, " carry_out"}, {31'd0, bus.carry_out}, {31'd0, v.pre_carry});
    sb.push_back(v.next_bcd);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.clear = 1'b0; bus.load = 1'b0; bus.load_value = 8'h00; bus.en = 1'b0;
  endtask

  vec_t tbl[19];
  vec_t v;

  initial begin
    checks = 0;
    errors = 0;
    bus.clear = 1'b0; bus.load = 1'b0; bus.load_value = 8'h00; bus.en = 1'b0;
    init_n = 1'b0;

    //         clr   ld    lv     en    at_max            carry              next
    tbl[0]  = '{1'b0, 1'b1, 8'h08, 1'b0, 1'b0,            1'b0,              8'h08};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0,            1'b0,              8'h09};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0,            1'b0,              8'h10};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0,            1'b0,              8'h11};
    tbl[4]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0,            1'b0,              8'h30};
    tbl[5]  = '{1'b0, 1'b1, 8'h75, 1'b0, 1'b0,            1'b0,              8'h00};
    tbl[6]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b0,            1'b0,              8'h12};
    tbl[7]  = '{1'b0, 1'b1, 8'h20, 1'b0, 1'b0,            1'b0,              8'h20};
    tbl[8]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0,            1'b0,              8'h00};
    tbl[9]  = '{1'b0, 1'b1, 8'h58, 1'b0, 1'b0,            1'b0,              8'h58};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0,            1'b0,              8'h59};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1,            !SAT,              SAT ? 8'h59 : 8'h00};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, SAT,             1'b0,              SAT ? 8'h59 : 8'h01};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, SAT,             1'b0,              SAT ? 8'h59 : 8'h02};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, SAT,             1'b0,              SAT ? 8'h59 : 8'h02};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b0, SAT,             1'b0,              8'h00};
    tbl[16] = '{1'b0, 1'b1, 8'h59, 1'b1, 1'b0,            1'b0,              8'h59};
    tbl[17] = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1,            !SAT,              8'h05};
    tbl[18] = '{1'b0, 1'b1, 8'h9F, 1'b0, 1'b0,            1'b0,              8'h00};

    // Power-up reset: cleared without any clock edge having occurred.
    #2;
    chk("reset bcd_out", {24'd0, bus.bcd_out}, 32'h0);
    chk("reset at_max",  {31'd0, bus.at_max},  32'h0);
    chk("reset carry",   {31'd0, bus.carry_out}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    init_n = 1'b1;

    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("vec%0d", i));
    idle();
    @(posedge clk);
    #3;

    // Reset mid-count at 37 must clear before the next edge, then count resumes from 0.
    v = '{1'b0, 1'b1, 8'h37, 1'b0, 1'b0, 1'b0, 8'h37};
    step(v, "preset37");
    idle();
    #2;
    init_n = 1'b0;
    #1;
    chk("async reset bcd_out", {24'd0, bus.bcd_out}, 32'h0);
    chk("async reset at_max",  {31'd0, bus.at_max},  32'h0);
    @(negedge clk);
    init_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      v = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'(i)};
      step(v, $sformatf("resume%0d", i));
    end
    idle();

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
